// File: rtl/pipe_stage_buf_pkg.sv
// pipe_stage_buf_pkg: shared constants and helpers for the elastic pipeline stage.
//   DEPTH_MIN / DEPTH_MAX : legal range of buffer entries.
//   ptr_width()           : bits needed to index a DEPTH-entry buffer (at least 1).
package pipe_stage_buf_pkg;

  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 4;

  // A single-entry buffer still needs a 1-bit pointer so the port/vector is legal.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_stage_buf_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   CLK   : system clock, rising edge
//   RST   : asynchronous, active-high reset (count -> 0)
//   inc   : count this cycle
//   count : current value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline stage with a DEPTH-entry circular buffer.
// Carries a DATA_W-bit payload plus a halt bit between two pipeline stages.
//   CLK, RST                  : clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready         : upstream handshake; in_data, in_halt payload
//   out_valid/out_ready       : downstream handshake; out_data, out_halt head payload
//   flush                     : synchronous kill of all entries (dominates everything)
//   enable                    : global advance; 0 freezes storage and pointers
//   halt_latched              : sticky, set once a halt entry has been popped
//   occupancy                 : number of buffered entries
//   stall_cnt / bubble_cnt    : saturating performance counters
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_halt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_halt,
  input  logic                       flush,
  input  logic                       enable,
  output logic                       halt_latched,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              halt;
    logic [DATA_W-1:0] data;
  } stage_entry_t;

  generate
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("pipe_stage_buf: DEPTH=%0d outside supported range 1..4", DEPTH);
    end
  endgenerate

  stage_entry_t     entries [DEPTH];
  stage_entry_t     head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] occ;
  logic             halt_q;
  logic             push;
  logic             pop;

  // Wraps at DEPTH-1 explicitly, so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered state: no path from out_ready.
  assign in_ready  = !RST && (occ < OCC_W'(DEPTH)) && !halt_q;
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready && enable && !flush;
  assign pop       = out_valid && out_ready && enable && !flush;

  assign head_entry = entries[head];
  assign out_data   = out_valid ? head_entry.data : '0;
  assign out_halt   = out_valid ? head_entry.halt : 1'b0;

  assign halt_latched = halt_q;
  assign occupancy    = occ;

  // NOTE: payload storage has no reset; occupancy alone defines which entries
  // are live, and the outputs are masked to 0 while the stage is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      entries[tail] <= '{halt: in_halt, data: in_data};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Sticky until reset; flush does not clear it, buffered entries may still drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q <= 1'b0;
    end else if (pop && head_entry.halt) begin
      halt_q <= 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (in_valid && !push && !RST),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (!out_valid && !halt_q && !RST),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: DEPTH=2 (table + halt sequence),
// DEPTH=3 (pointer wrap, enable freeze), DEPTH=1 with narrow counters (saturation).
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: DEPTH=2 ----------------
  logic        a_iv, a_ir, a_ih, a_ov, a_or, a_oh, a_fl, a_en, a_hl;
  logic [15:0] a_id, a_od;
  logic [1:0]  a_occ;
  logic [31:0] a_stall, a_bubble;

  pipe_stage_buf #(.DATA_W(16), .DEPTH(2), .CNT_W(32)) dut_a (
    .CLK(clk), .RST(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_halt(a_ih), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
    .out_halt(a_oh), .flush(a_fl), .enable(a_en), .halt_latched(a_hl),
    .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  // ---------------- DUT B: DEPTH=3 ----------------
  logic        b_iv, b_ir, b_ih, b_ov, b_or, b_oh, b_fl, b_en, b_hl;
  logic [15:0] b_id, b_od;
  logic [1:0]  b_occ;
  logic [31:0] b_stall, b_bubble;

  pipe_stage_buf #(.DATA_W(16), .DEPTH(3), .CNT_W(32)) dut_b (
    .CLK(clk), .RST(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_halt(b_ih), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
    .out_halt(b_oh), .flush(b_fl), .enable(b_en), .halt_latched(b_hl),
    .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  // ---------------- DUT C: DEPTH=1, 3-bit counters ----------------
  logic        c_iv, c_ir, c_ih, c_ov, c_or, c_oh, c_fl, c_en, c_hl;
  logic [15:0] c_id, c_od;
  logic [0:0]  c_occ;
  logic [2:0]  c_stall, c_bubble;

  pipe_stage_buf #(.DATA_W(16), .DEPTH(1), .CNT_W(3)) dut_c (
    .CLK(clk), .RST(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .in_halt(c_ih), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
    .out_halt(c_oh), .flush(c_fl), .enable(c_en), .halt_latched(c_hl),
    .occupancy(c_occ), .stall_cnt(c_stall), .bubble_cnt(c_bubble)
  );

  // One table row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ordy;
    logic        fl;
    logic        en;
    logic        ev;
    logic [15:0] ed;
    logic        eir;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic ordy,
                              input logic fl, input logic en, input logic ev,
                              input logic [15:0] ed, input logic eir, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.en = en;
    v.ev = ev; v.ed = ed; v.eir = eir; v.eocc = eocc;
    return v;
  endfunction

  initial begin
    // Streaming, out_ready=1: one-cycle latency, one entry per cycle.
    vecs[0]  = mk(1'b1, 16'h000A, 1'b1, 1'b0, 1'b1,  1'b1, 16'h000A, 1'b1, 2'd1);
    vecs[1]  = mk(1'b1, 16'h000B, 1'b1, 1'b0, 1'b1,  1'b1, 16'h000B, 1'b1, 2'd1);
    vecs[2]  = mk(1'b1, 16'h000C, 1'b1, 1'b0, 1'b1,  1'b1, 16'h000C, 1'b1, 2'd1);
    vecs[3]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0);
    // Backpressure: third entry held upstream until a slot frees.
    vecs[4]  = mk(1'b1, 16'h000D, 1'b0, 1'b0, 1'b1,  1'b1, 16'h000D, 1'b1, 2'd1);
    vecs[5]  = mk(1'b1, 16'h000E, 1'b0, 1'b0, 1'b1,  1'b1, 16'h000D, 1'b0, 2'd2);
    vecs[6]  = mk(1'b1, 16'h000F, 1'b0, 1'b0, 1'b1,  1'b1, 16'h000D, 1'b0, 2'd2);
    vecs[7]  = mk(1'b1, 16'h000F, 1'b0, 1'b0, 1'b1,  1'b1, 16'h000D, 1'b0, 2'd2);
    vecs[8]  = mk(1'b1, 16'h000F, 1'b1, 1'b0, 1'b1,  1'b1, 16'h000E, 1'b1, 2'd1);
    vecs[9]  = mk(1'b1, 16'h000F, 1'b1, 1'b0, 1'b1,  1'b1, 16'h000F, 1'b1, 2'd1);
    vecs[10] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0);
    // Flush while full with an entry offered: the offered entry is discarded.
    vecs[11] = mk(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1,  1'b1, 16'h0011, 1'b1, 2'd1);
    vecs[12] = mk(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1,  1'b1, 16'h0011, 1'b0, 2'd2);
    vecs[13] = mk(1'b1, 16'h0033, 1'b0, 1'b1, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0);
    vecs[14] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1,  1'b0, 16'h0000, 1'b1, 2'd0);
    // Flush dominates enable=0.
    vecs[15] = mk(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1,  1'b1, 16'h0055, 1'b1, 2'd1);
    vecs[16] = mk(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0,  1'b0, 16'h0000, 1'b1, 2'd0);
  end

  initial begin
    a_iv = 1'b0; a_id = '0; a_ih = 1'b0; a_or = 1'b0; a_fl = 1'b0; a_en = 1'b1;
    b_iv = 1'b0; b_id = '0; b_ih = 1'b0; b_or = 1'b0; b_fl = 1'b0; b_en = 1'b1;
    c_iv = 1'b0; c_id = '0; c_ih = 1'b0; c_or = 1'b0; c_fl = 1'b0; c_en = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_in_ready", {63'b0, a_ir}, 64'd0);
    check("rst_out_valid", {63'b0, a_ov}, 64'd0);
    step();
    step();
    rst = 1'b0;

    // ---- Idle 5 cycles after reset ----
    repeat (5) step();
    check("idle_in_ready", {63'b0, a_ir}, 64'd1);
    check("idle_out_valid", {63'b0, a_ov}, 64'd0);
    check("idle_out_data", {48'b0, a_od}, 64'd0);
    check("idle_out_halt", {63'b0, a_oh}, 64'd0);
    check("idle_occ", {62'b0, a_occ}, 64'd0);
    check("idle_halt_latched", {63'b0, a_hl}, 64'd0);
    check("idle_stall", {32'b0, a_stall}, 64'd0);
    check("idle_bubble", {32'b0, a_bubble}, 64'd5);

    // ---- Table-driven vectors on DEPTH=2 ----
    for (int i = 0; i < 17; i++) begin
      a_iv = vecs[i].iv; a_id = vecs[i].id; a_or = vecs[i].ordy;
      a_fl = vecs[i].fl; a_en = vecs[i].en;
      step();
      check($sformatf("vec%0d_out_valid", i), {63'b0, a_ov}, {63'b0, vecs[i].ev});
      check($sformatf("vec%0d_out_data", i), {48'b0, a_od}, {48'b0, vecs[i].ed});
      check($sformatf("vec%0d_in_ready", i), {63'b0, a_ir}, {63'b0, vecs[i].eir});
      check($sformatf("vec%0d_occ", i), {62'b0, a_occ}, {62'b0, vecs[i].eocc});
      if (i == 3) begin
        check("stream_stall", {32'b0, a_stall}, 64'd0);
        check("stream_bubble", {32'b0, a_bubble}, 64'd6);
      end
      if (i == 10) begin
        check("backpressure_stall", {32'b0, a_stall}, 64'd3);
        check("backpressure_bubble", {32'b0, a_bubble}, 64'd7);
      end
    end
    check("table_stall", {32'b0, a_stall}, 64'd4);
    check("table_bubble", {32'b0, a_bubble}, 64'd10);
    a_fl = 1'b0; a_en = 1'b1;

    // ---- Halt sequence on DEPTH=2 ----
    a_iv = 1'b1; a_id = 16'h0044; a_ih = 1'b1; a_or = 1'b0;
    step();
    check("halt_push_out_halt", {63'b0, a_oh}, 64'd1);
    check("halt_push_latched", {63'b0, a_hl}, 64'd0);
    a_id = 16'h0066; a_ih = 1'b0;
    step();
    check("halt_fill_occ", {62'b0, a_occ}, 64'd2);
    a_iv = 1'b0; a_or = 1'b1;
    step();
    check("halt_pop_latched", {63'b0, a_hl}, 64'd1);
    check("halt_pop_in_ready", {63'b0, a_ir}, 64'd0);
    check("halt_pop_out_data", {48'b0, a_od}, 64'h66);
    check("halt_pop_out_halt", {63'b0, a_oh}, 64'd0);
    step();
    check("halt_drain_out_valid", {63'b0, a_ov}, 64'd0);
    repeat (3) step();
    check("halt_bubble_frozen", {32'b0, a_bubble}, 64'd11);
    a_iv = 1'b1; a_id = 16'h0077; a_fl = 1'b1;
    step();
    check("halt_flush_keeps_latch", {63'b0, a_hl}, 64'd1);
    a_fl = 1'b0;
    b_iv = 1'b1; b_id = 16'h0088; b_or = 1'b0;
    step();
    check("halt_in_ready_stays_0", {63'b0, a_ir}, 64'd0);
    check("halt_occ_empty", {62'b0, a_occ}, 64'd0);
    check("halt_stall", {32'b0, a_stall}, 64'd6);
    check("b_pre_reset_valid", {63'b0, b_ov}, 64'd1);

    // ---- Asynchronous reset mid-transfer ----
    a_iv = 1'b0; b_iv = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_latch", {63'b0, a_hl}, 64'd0);
    check("async_rst_in_ready", {63'b0, a_ir}, 64'd0);
    check("async_rst_stall", {32'b0, a_stall}, 64'd0);
    check("async_rst_b_valid", {63'b0, b_ov}, 64'd0);
    check("async_rst_b_data", {48'b0, b_od}, 64'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {63'b0, a_ir}, 64'd1);
    check("post_rst_b_occ", {62'b0, b_occ}, 64'd0);

    // ---- DEPTH=3: pointer wrap with 7 push/pop pairs and an enable freeze ----
    b_iv = 1'b1; b_or = 1'b0; b_id = 16'h0100;
    step();
    b_id = 16'h0101;
    step();
    check("d3_fill_occ", {62'b0, b_occ}, 64'd2);
    check("d3_fill_head", {48'b0, b_od}, 64'h100);
    b_or = 1'b1;
    for (int k = 0; k < 7; k++) begin
      b_id = 16'h0102 + 16'(k);
      step();
      check($sformatf("d3_pair%0d_data", k), {48'b0, b_od}, 64'h101 + 64'(k));
      check($sformatf("d3_pair%0d_occ", k), {62'b0, b_occ}, 64'd2);
      if (k == 3) begin
        b_en = 1'b0;
        b_id = 16'h0106;
        repeat (3) step();
        check("d3_freeze_data", {48'b0, b_od}, 64'h104);
        check("d3_freeze_occ", {62'b0, b_occ}, 64'd2);
        check("d3_freeze_stall", {32'b0, b_stall}, 64'd3);
        b_en = 1'b1;
      end
    end
    b_iv = 1'b0;
    step();
    check("d3_drain1_data", {48'b0, b_od}, 64'h108);
    check("d3_drain1_occ", {62'b0, b_occ}, 64'd1);
    step();
    check("d3_drain2_valid", {63'b0, b_ov}, 64'd0);
    check("d3_stall_total", {32'b0, b_stall}, 64'd3);

    // ---- DEPTH=1: half throughput and counter saturation ----
    check("d1_bubble_saturated", {61'b0, c_bubble}, 64'd7);
    c_iv = 1'b1; c_or = 1'b1; c_id = 16'h0001;
    step();
    check("d1_push1_data", {48'b0, c_od}, 64'h1);
    check("d1_push1_in_ready", {63'b0, c_ir}, 64'd0);
    c_id = 16'h0002;
    step();
    check("d1_pop1_valid", {63'b0, c_ov}, 64'd0);
    check("d1_pop1_stall", {61'b0, c_stall}, 64'd1);
    step();
    check("d1_push2_data", {48'b0, c_od}, 64'h2);
    step();
    check("d1_pop2_stall", {61'b0, c_stall}, 64'd2);
    repeat (16) step();
    check("d1_stall_saturated", {61'b0, c_stall}, 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline stage, the successor to the fixed enable/flush inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_W-bit bundle plus a halt bit through a DEPTH-entry circular buffer.
- Uses a valid/ready handshake on both sides, with synchronous flush, a global enable, a sticky halt latch and saturating stall/bubble counters.
- Drop-in between any two pipeline stages; the hazard unit drives flush and enable.

Parameters:
- DATA_W, 96, width of the payload bundle (ALU result, store data, control fields, tracker pass-through).
- DEPTH, 2, number of buffer entries; legal range 1..4.
- CNT_W, 32, width of the performance counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage accepts an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_halt  input  1  entry carries a halt instruction.
- out_valid  output  1  head entry is available.
- out_ready  input  1  downstream consumes the head entry.
- out_data  output  DATA_W  head payload.
- out_halt  output  1  head entry's halt bit.
- flush  input  1  synchronous kill of all entries.
- enable  input  1  global advance; 0 freezes the stage.
- halt_latched  output  1  a halt entry has left the stage.
- occupancy  output  $clog2(DEPTH+1)  current entry count.
- stall_cnt  output  CNT_W  cycles with upstream blocked.
- bubble_cnt  output  CNT_W  cycles with no output entry.

Behaviour:
- Reset (RST=1, asynchronous): entries invalid; head and tail pointers, occupancy, halt_latched, stall_cnt and bubble_cnt all 0. in_ready is forced 0 while RST=1. out_valid, out_data and out_halt are 0.
- in_ready = !RST && (occupancy < DEPTH) && !halt_latched. It depends on registered state only; there is no combinational path from out_ready.
- push = in_valid && in_ready && enable && !flush. pop = out_valid && out_ready && enable && !flush.
- out_valid = (occupancy != 0). out_data and out_halt come from the head entry when out_valid=1 and are forced to 0 when out_valid=0.
- Latency: an entry pushed at edge N is visible at out_valid after edge N; minimum one cycle, no bypass.
- Push writes the tail entry and tail advances modulo DEPTH. Pop advances head modulo DEPTH. Pointers wrap at DEPTH-1 -> 0, including non-power-of-two DEPTH.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. With DEPTH=1 a full stage cannot push in the pop cycle, so throughput is one entry per two cycles. DEPTH>=2 sustains one entry per cycle.
- flush=1: at the next edge occupancy=0 and head=tail=0, and any in_data offered that cycle is discarded. Flush dominates push, pop and enable. It does not clear halt_latched or the counters.
- enable=0 (and flush=0): no push, no pop, storage and pointers hold; outputs keep showing the head entry.
- halt_latched: set at the edge where pop occurs with out_halt=1. It is sticky until RST and forces in_ready=0. Entries already buffered may still drain.
- stall_cnt: increments each cycle with in_valid=1 && push=0 && !RST, including enable=0 cycles. Saturates at all-ones.
- bubble_cnt: increments each cycle with out_valid=0 && halt_latched=0 && !RST. Saturates at all-ones.
- Reset asserted mid-transfer: buffered entries are lost and no partial pop is reported.
- Behaviour outside DEPTH 1..4 is undefined; an elaboration-time check flags it.

Decomposition:
- cpu_types_pkg gains a stage_entry_t struct { logic halt; logic [DATA_W-1:0] data } pattern plus the DEPTH bounds constants.
- Stages pack their existing word_t, regbits_t and mux-selection fields into the DATA_W bundle at the instantiation site.
- One natural sub-module: sat_counter (parameter CNT_W; inputs CLK, RST, inc; output count), instantiated twice.
- Storage, pointers and handshake logic stay in pipe_stage_buf.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0 except in_ready=1; bubble_cnt=5.
- DEPTH=2, out_ready=1, push 0xA, 0xB, 0xC on consecutive cycles -> out_data 0xA, 0xB, 0xC on the following consecutive cycles; stall_cnt=0.
- DEPTH=2, out_ready=0, push 3 entries -> occupancy=2, in_ready=0, third entry held upstream; stall_cnt increments once per blocked cycle; raising out_ready drains 2 entries, then the third is accepted.
- Occupancy=2 with flush and in_valid asserted together -> next cycle occupancy=0, out_valid=0; the offered entry never appears at out_data.
- Push entry with in_halt=1 and pop it -> halt_latched=1 from the next cycle and in_ready stays 0; flush does not clear it; RST clears it.
- DEPTH=3 with 7 push/pop pairs -> correct data order across pointer wrap 2->0; hold enable=0 for 3 cycles mid-stream -> data and occupancy frozen, stall_cnt +3.
